mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (M) stage and M/W pipeline register of the RV32I pipeline. It sits directly upstream of the writeback stage.

- Issues loads and stores to the external data memory over a req/gnt/rvalid handshake.
- Generates byte enables and store-data lane steering.
- Right-aligns load data so the writeback stage's sign/zero extension can operate on bits [7:0]/[15:0].
- Stalls the upstream pipeline while a memory transaction is outstanding.

## Interface

Parameters:
- P_WIDTH, 32, datapath/address width.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_alu_result_m  in  P_WIDTH  ALU result; the memory address for loads/stores.
- i_write_data_m  in  P_WIDTH  store data (rs2).
- i_pc_plus_4_m  in  11  PC+4.
- i_sel_m  in  2  writeback result select, passed through.
- i_f3_m  in  3  funct3 (access size/sign).
- i_rd_m  in  5  destination register.
- i_reg_write_m  in  1  register write enable.
- i_mem_read_m  in  1  load in M.
- i_mem_write_m  in  1  store in M.
- o_stall_m  out  1  hold the M stage and everything upstream.
- o_misaligned_m  out  1  misaligned access detected (MISALIGN_TRAP_EN builds only; tied 0 otherwise).
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  P_WIDTH  word address, {addr[31:2],2'b00}.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  P_WIDTH  lane-steered store data.
- i_dmem_gnt  in  1  request accepted.
- i_dmem_rvalid  in  1  load data valid.
- i_dmem_rdata  in  P_WIDTH  load data.
- o_alu_result_w, o_mem_data_w  out  P_WIDTH  registered to writeback.
- o_pc_plus_4_w  out  11  registered to writeback.
- o_sel_w  out  2  registered to writeback.
- o_f3_w  out  3  registered to writeback.
- o_rd_w  out  5  registered to writeback.
- o_reg_write_w  out  1  registered to writeback.

## Operation

**FSM states**
- IDLE: no load outstanding.
- WAIT_RSP: load granted, awaiting rvalid.

**IDLE**
- A memory op (read or write, not misaligned-trapped) drives o_dmem_req=1 combinationally.
- Store with gnt: completes this cycle; stays in IDLE.
- Load with gnt: goes to WAIT_RSP.
- No gnt: o_dmem_req stays high and the inputs are held by the stall.

**WAIT_RSP**
- o_dmem_req=0.
- On rvalid: return to IDLE.
- rvalid in IDLE is ignored.

**Stall**
- o_stall_m = (IDLE & memop & !(store & gnt)) | (WAIT_RSP & !rvalid).

**Byte enables** (off = addr[1:0])
- SB: 4'b0001<<off.
- SH: 4'b0011<<{off[1],1'b0}.
- SW: 4'b1111.

**Store data**
- SB: byte replicated to all 4 lanes.
- SH: halfword replicated to both halves.
- SW: unchanged.

**Load alignment**
- o_mem_data_w = i_dmem_rdata >> (8*off_eff).
- off_eff is off for byte accesses, {off[1],0} for half, 0 for word.

**M/W register**
- Updates when o_stall_m=0, loading all M fields.
- For loads, it loads the aligned rdata.
- While o_stall_m=1, it loads a bubble: o_reg_write_w=0, other fields unchanged.

**Non-memory instructions** pass through with no request and no stall.

## Timing

**Reset**
- All outputs 0.
- FSM in IDLE.
- Reset during WAIT_RSP abandons the load; a later stray rvalid is ignored.

**Latency**
- Non-memory ops and stores granted in the first cycle: 1 cycle M→W, zero stall cycles.
- Load granted in cycle N with rvalid in cycle N+k (k≥1): k stall cycles; W updated at the end of N+k.
- Each cycle without gnt adds one stall cycle.

**Bus stability**
- While o_dmem_req=1 and gnt=0, o_dmem_addr/we/be/wdata stay stable.

## Configuration

MISALIGN_TRAP_EN.

Misaligned means: half with off[0]=1, or word with off≠0.

- **Defined:** a misaligned memop asserts o_misaligned_m for that cycle, issues no request and no stall. W receives a bubble (o_reg_write_w=0).
- **Undefined:** o_misaligned_m=0. The access is issued using off_eff, which drops the offending low bits (word forced to offset 0, half to offset 0/2).

## Test plan

- **ALU op:** i_alu_result_m=0x1234, reg_write=1, no memop → next cycle o_alu_result_w=0x1234, o_reg_write_w=1, o_dmem_req never 1.
- **SB:** addr 0x103, wdata 0xAB, gnt immediate → o_dmem_be=4'b1000, o_dmem_wdata=0xABABABAB, o_dmem_addr=0x100, no stall.
- **LH:** addr 0x202, gnt after 2 cycles, rvalid 3 cycles later with rdata 0x8001_7FFF → o_stall_m high for 5 cycles. Then o_mem_data_w=0x0000_8001, o_f3_w=3'b001, o_reg_write_w=1; bubbles (reg_write_w=0) during the stall.
- **Misaligned LW:** LW at 0x301 → with MISALIGN_TRAP_EN: o_misaligned_m=1, no req, o_reg_write_w=0. Without it: req at 0x300, be=4'b1111.
- **Reset mid-load:** i_rst pulsed during WAIT_RSP, then rvalid=1 → outputs 0, FSM IDLE, rvalid ignored.
- **Back-to-back:** SW then LW, both granted immediately, rvalid next cycle → one stall cycle total; W shows the store bubble-free, then the load data.

Source files
------------

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage with M/W pipeline register and req/gnt/rvalid data-memory port.
// Optional feature: define MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module mem_access_stage #(
  parameter int P_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [P_WIDTH-1:0] i_alu_result_m,
  input  logic [P_WIDTH-1:0] i_write_data_m,
  input  logic [10:0]        i_pc_plus_4_m,
  input  logic [1:0]         i_sel_m,
  input  logic [2:0]         i_f3_m,
  input  logic [4:0]         i_rd_m,
  input  logic               i_reg_write_m,
  input  logic               i_mem_read_m,
  input  logic               i_mem_write_m,
  output logic               o_stall_m,
  output logic               o_misaligned_m,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [P_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]         o_dmem_be,
  output logic [P_WIDTH-1:0] o_dmem_wdata,
  input  logic               i_dmem_gnt,
  input  logic               i_dmem_rvalid,
  input  logic [P_WIDTH-1:0] i_dmem_rdata,
  output logic [P_WIDTH-1:0] o_alu_result_w,
  output logic [P_WIDTH-1:0] o_mem_data_w,
  output logic [10:0]        o_pc_plus_4_w,
  output logic [1:0]         o_sel_w,
  output logic [2:0]         o_f3_w,
  output logic [4:0]         o_rd_w,
  output logic               o_reg_write_w
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_RSP
  } state_t;

  state_t state_q, state_d;

  logic [P_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [P_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [10:0]        pc_plus_4_q, pc_plus_4_d;
  logic [1:0]         sel_q, sel_d;
  logic [2:0]         f3_q, f3_d;
  logic [4:0]         rd_q, rd_d;
  logic               reg_write_q, reg_write_d;

  logic [1:0]         off;
  logic [1:0]         off_eff;
  logic [3:0]         be;
  logic [P_WIDTH-1:0] wdata;
  logic [P_WIDTH-1:0] rdata_aligned;
  logic               memop;
  logic               trap;
  logic               active;
  logic               req;
  logic               stall;

  assign off   = i_alu_result_m[1:0];
  assign memop = i_mem_read_m | i_mem_write_m;

  // Size decode: off_eff drops the low offset bits a half/word access cannot use.
  always_comb begin
    off_eff = 2'b00;
    be      = 4'b1111;
    wdata   = i_write_data_m;
    case (i_f3_m[1:0])
      2'b00: begin
        off_eff = off;
        be      = 4'b0001 << off;
        wdata   = P_WIDTH'({4{i_write_data_m[7:0]}});
      end
      2'b01: begin
        off_eff = {off[1], 1'b0};
        be      = 4'b0011 << {off[1], 1'b0};
        wdata   = P_WIDTH'({2{i_write_data_m[15:0]}});
      end
      default: begin
        off_eff = 2'b00;
        be      = 4'b1111;
        wdata   = i_write_data_m;
      end
    endcase
  end

  assign rdata_aligned = i_dmem_rdata >> {off_eff, 3'b000};

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned     = ((i_f3_m[1:0] == 2'b01) & off[0]) |
                          (i_f3_m[1]              & (off != 2'b00));
  assign trap           = memop & misaligned;
  assign o_misaligned_m = trap;
`else
  assign trap           = 1'b0;
  assign o_misaligned_m = 1'b0;
`endif

  assign active = memop & ~trap;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req   = active;
        stall = active & ~(i_mem_write_m & i_dmem_gnt);
        if (active && !i_mem_write_m && i_dmem_gnt) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        stall = ~i_dmem_rvalid;
        if (i_dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_stall_m    = stall;
  assign o_dmem_req   = req;
  assign o_dmem_we    = req & i_mem_write_m;
  assign o_dmem_addr  = req ? {i_alu_result_m[P_WIDTH-1:2], 2'b00} : '0;
  assign o_dmem_be    = req ? be : '0;
  assign o_dmem_wdata = (req & i_mem_write_m) ? wdata : '0;

  // Stalled or trapped cycles hold W and drop reg_write to form a bubble.
  always_comb begin
    alu_result_d = alu_result_q;
    mem_data_d   = mem_data_q;
    pc_plus_4_d  = pc_plus_4_q;
    sel_d        = sel_q;
    f3_d         = f3_q;
    rd_d         = rd_q;
    reg_write_d  = 1'b0;
    if (!stall && !trap) begin
      alu_result_d = i_alu_result_m;
      pc_plus_4_d  = i_pc_plus_4_m;
      sel_d        = i_sel_m;
      f3_d         = i_f3_m;
      rd_d         = i_rd_m;
      reg_write_d  = i_reg_write_m;
      if (state_q == ST_WAIT_RSP) mem_data_d = rdata_aligned;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      pc_plus_4_q  <= '0;
      sel_q        <= '0;
      f3_q         <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      pc_plus_4_q  <= pc_plus_4_d;
      sel_q        <= sel_d;
      f3_q         <= f3_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign o_alu_result_w = alu_result_q;
  assign o_mem_data_w   = mem_data_q;
  assign o_pc_plus_4_w  = pc_plus_4_q;
  assign o_sel_w        = sel_q;
  assign o_f3_w         = f3_q;
  assign o_rd_w         = rd_q;
  assign o_reg_write_w  = reg_write_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// transactions checked against a transaction-level model of the memory stage.
module tb_mem_access_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_alu_result_m, i_write_data_m;
  logic [10:0] i_pc_plus_4_m;
  logic [1:0]  i_sel_m;
  logic [2:0]  i_f3_m;
  logic [4:0]  i_rd_m;
  logic        i_reg_write_m, i_mem_read_m, i_mem_write_m;
  logic        o_stall_m, o_misaligned_m, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_alu_result_w, o_mem_data_w;
  logic [10:0] o_pc_plus_4_w;
  logic [1:0]  o_sel_w;
  logic [2:0]  o_f3_w;
  logic [4:0]  o_rd_w;
  logic        o_reg_write_w;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_mem = '0;

  always #5 i_clk = ~i_clk;

  mem_access_stage #(.P_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_result_m(i_alu_result_m), .i_write_data_m(i_write_data_m),
    .i_pc_plus_4_m(i_pc_plus_4_m), .i_sel_m(i_sel_m), .i_f3_m(i_f3_m),
    .i_rd_m(i_rd_m), .i_reg_write_m(i_reg_write_m),
    .i_mem_read_m(i_mem_read_m), .i_mem_write_m(i_mem_write_m),
    .o_stall_m(o_stall_m), .o_misaligned_m(o_misaligned_m),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_alu_result_w(o_alu_result_w), .o_mem_data_w(o_mem_data_w),
    .o_pc_plus_4_w(o_pc_plus_4_w), .o_sel_w(o_sel_w), .o_f3_w(o_f3_w),
    .o_rd_w(o_rd_w), .o_reg_write_w(o_reg_write_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and the arithmetic consequences of it.
  function automatic int unsigned sz(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction
  function automatic int unsigned offe(input logic [31:0] a, input logic [2:0] f3);
    return (a % 4) - ((a % 4) % sz(f3));
  endfunction
  function automatic logic [3:0] be_m(input logic [31:0] a, input logic [2:0] f3);
    return 4'(((1 << sz(f3)) - 1) << offe(a, f3));
  endfunction
  function automatic logic [31:0] wd_m(input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] r;
    for (int unsigned i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz(f3)) +: 8];
    return r;
  endfunction
  function automatic logic mis_m(input logic [31:0] a, input logic [2:0] f3);
    return ((a % 4) % sz(f3)) != 0;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. g = cycles without gnt, k = gnt-to-rvalid delay.
  task automatic do_op(input int unsigned kind, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input int unsigned g, input int unsigned k,
                       input logic [31:0] rdata);
    logic        trap;
    logic        memop;
    int unsigned stalls;
    logic [10:0] pc;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    pc = 11'($urandom); sel = 2'($urandom); rd = 5'($urandom); rw = 1'b1;
    i_alu_result_m = addr; i_write_data_m = wd; i_f3_m = f3;
    i_pc_plus_4_m = pc; i_sel_m = sel; i_rd_m = rd; i_reg_write_m = rw;
    i_mem_read_m = (kind == 1); i_mem_write_m = (kind == 2);
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    memop = (kind != 0);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = memop && mis_m(addr, f3);
`endif
    stalls = 0;
    if (!memop || trap) begin
      i_dmem_gnt = 1'b1;
      #1;
      chk("idle_req", 32'(o_dmem_req), 0);
      chk("idle_stall", 32'(o_stall_m), 0);
      chk("misaligned", 32'(o_misaligned_m), 32'(trap));
      @(posedge i_clk); #1;
      i_dmem_gnt = 1'b0;
    end else begin
      for (int unsigned c = 0; c <= g; c++) begin
        i_dmem_gnt = (c == g);
        i_dmem_rdata = $urandom;
        #1;
        chk("req", 32'(o_dmem_req), 1);
        chk("we", 32'(o_dmem_we), 32'(kind == 2));
        chk("addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
        chk("be", 32'(o_dmem_be), 32'(be_m(addr, f3)));
        if (kind == 2) chk("wdata", o_dmem_wdata, wd_m(wd, f3));
        if (o_stall_m) stalls++;
        @(posedge i_clk); #1;
        if (!(kind == 2 && c == g)) chk("bubble_req", 32'(o_reg_write_w), 0);
      end
      i_dmem_gnt = 1'b0;
      if (kind == 1) begin
        for (int unsigned j = 1; j <= k; j++) begin
          i_dmem_rvalid = (j == k);
          i_dmem_rdata = (j == k) ? rdata : $urandom;
          #1;
          chk("wait_req", 32'(o_dmem_req), 0);
          if (o_stall_m) stalls++;
          @(posedge i_clk); #1;
          if (j < k) chk("bubble_rsp", 32'(o_reg_write_w), 0);
        end
        i_dmem_rvalid = 1'b0;
        exp_mem = rdata >> (8 * offe(addr, f3));
      end
      chk("stall_cycles", stalls, g + ((kind == 1) ? k : 0));
    end
    chk("w_reg_write", 32'(o_reg_write_w), 32'(rw && !trap));
    if (!trap) begin
      chk("w_alu", o_alu_result_w, addr);
      chk("w_pc", 32'(o_pc_plus_4_w), 32'(pc));
      chk("w_sel", 32'(o_sel_w), 32'(sel));
      chk("w_f3", 32'(o_f3_w), 32'(f3));
      chk("w_rd", 32'(o_rd_w), 32'(rd));
      chk("w_mem", o_mem_data_w, exp_mem);
    end
  endtask

  initial begin
    logic [2:0] f3s [5];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    i_rst = 1'b1;
    i_alu_result_m = '0; i_write_data_m = '0; i_pc_plus_4_m = '0; i_sel_m = '0;
    i_f3_m = '0; i_rd_m = '0; i_reg_write_m = 1'b0; i_mem_read_m = 1'b0;
    i_mem_write_m = 1'b0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    #1;
    chk("rst_alu", o_alu_result_w, 0);
    chk("rst_mem", o_mem_data_w, 0);
    chk("rst_rw", 32'(o_reg_write_w), 0);
    chk("rst_req", 32'(o_dmem_req), 0);
    chk("rst_stall", 32'(o_stall_m), 0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;

    do_op(0, 32'h0000_1234, 32'h0, 3'b010, 0, 0, 32'h0);           // ALU op
    do_op(2, 32'h0000_0103, 32'h0000_00AB, 3'b000, 0, 0, 32'h0);   // SB
    do_op(1, 32'h0000_0202, 32'h0, 3'b001, 2, 3, 32'h8001_7FFF);   // LH, 5 stalls
    do_op(1, 32'h0000_0301, 32'h0, 3'b010, 0, 1, 32'hCAFE_F00D);   // misaligned LW
    do_op(2, 32'h0000_0400, 32'h1122_3344, 3'b010, 0, 0, 32'h0);   // SW
    do_op(1, 32'h0000_0404, 32'h0, 3'b010, 0, 1, 32'h5566_7788);   // LW back-to-back

    for (int unsigned n = 0; n < 40; n++) begin
      int unsigned kind;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      f3 = (kind == 2) ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)];
      do_op(kind, $urandom, $urandom, f3, $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
    end

    // Reset while a load waits for its response; a later rvalid must be ignored.
    i_alu_result_m = 32'h0000_0500; i_f3_m = 3'b010; i_mem_read_m = 1'b1;
    i_mem_write_m = 1'b0; i_reg_write_m = 1'b1; i_dmem_gnt = 1'b1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("rstmid_alu", o_alu_result_w, 0);
    chk("rstmid_mem", o_mem_data_w, 0);
    chk("rstmid_rw", 32'(o_reg_write_w), 0);
    i_alu_result_m = '0; i_f3_m = '0; i_mem_read_m = 1'b0; i_reg_write_m = 1'b0;
    i_pc_plus_4_m = '0; i_sel_m = '0; i_rd_m = '0;
    #1;
    chk("rstmid_req", 32'(o_dmem_req), 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stray_stall", 32'(o_stall_m), 0);
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1'b0;
    chk("stray_mem", o_mem_data_w, 0);
    chk("stray_rw", 32'(o_reg_write_w), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
